// File: rtl/fetch_issue_queue.sv
// fetch_issue_queue: buffers fetch pairs and issues 0-2 instructions per cycle to decode.
// Define ISSUE_STATS_EN to add saturating dual/single/empty issue counters.
module fetch_issue_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        fi_valid,
  input  logic [31:0] fi_inst1,
  input  logic [31:0] fi_inst2,
  input  logic [31:0] fi_pc1,
  input  logic [31:0] fi_pc2,
  output logic        fi_hold,
  input  logic        ex_setPC,
  input  logic        id_ready,
  output logic        id_valid0,
  output logic [31:0] id_inst0,
  output logic [31:0] id_pc0,
  output logic        id_valid1,
  output logic [31:0] id_inst1,
  output logic [31:0] id_pc1
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0] stat_dual,
  output logic [31:0] stat_single,
  output logic [31:0] stat_empty
`endif
);
  localparam logic [PTR_W:0] FULL_AT = (PTR_W+1)'(DEPTH - 2);
  logic [31:0] inst_q [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nx, wr_addr, wr_nx;
  logic [PTR_W:0] count;
  logic [5:0] op0;
  logic [4:0] dst0;
  logic jr0, ctl0, hazard, enq, we;
  logic [1:0] deq;
  assign rd_nx = rd_ptr + 1'b1;
  assign id_inst0 = inst_q[rd_ptr];
  assign id_pc0 = pc_q[rd_ptr];
  assign id_inst1 = inst_q[rd_nx];
  assign id_pc1 = pc_q[rd_nx];
  // Slot1 may only pair with slot0 when it does not read slot0's result and slot0 does not redirect.
  assign op0 = id_inst0[31:26];
  assign jr0 = op0 == 6'h00 && id_inst0[5:0] == 6'h08;
  assign ctl0 = jr0 || op0 inside {6'h02, 6'h03, 6'h04, 6'h05};
  assign dst0 = (op0 == 6'h00 && !jr0) ? id_inst0[15:11] :
                (op0 inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23}) ? id_inst0[20:16] : 5'd0;
  assign hazard = ctl0 || (dst0 != 5'd0 && (dst0 == id_inst1[25:21] || dst0 == id_inst1[20:16]));
  assign id_valid0 = !ex_setPC && count != '0;
  assign id_valid1 = !ex_setPC && count[PTR_W:1] != '0 && !hazard;
  assign fi_hold = !ex_setPC && count > FULL_AT;
  assign enq = fi_valid && count <= FULL_AT;
  assign deq = !id_ready ? 2'd0 : id_valid1 ? 2'd2 : {1'b0, id_valid0};
  // A flush restarts the buffer at entry 0 with the redirect-target pair.
  assign we = fi_valid && (ex_setPC || enq);
  assign wr_addr = ex_setPC ? '0 : wr_ptr;
  assign wr_nx = wr_addr + 1'b1;
  always_ff @(posedge CLK)
    if (we) begin
      inst_q[wr_addr] <= fi_inst1;
      pc_q[wr_addr] <= fi_pc1;
      inst_q[wr_nx] <= fi_inst2;
      pc_q[wr_nx] <= fi_pc2;
    end
  always_ff @(posedge CLK)
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (ex_setPC) begin
      rd_ptr <= '0;
      wr_ptr <= fi_valid ? PTR_W'(2) : '0;
      count <= fi_valid ? (PTR_W+1)'(2) : '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(deq);
      wr_ptr <= wr_ptr + (enq ? PTR_W'(2) : '0);
      count <= count + (enq ? (PTR_W+1)'(2) : '0) - (PTR_W+1)'(deq);
    end
`ifdef ISSUE_STATS_EN
  always_ff @(posedge CLK)
    if (RST) begin
      stat_dual <= '0;
      stat_single <= '0;
      stat_empty <= '0;
    end else if (!ex_setPC && id_ready) begin
      if (id_valid1) begin
        if (~&stat_dual) stat_dual <= stat_dual + 1'b1;
      end else if (id_valid0) begin
        if (~&stat_single) stat_single <= stat_single + 1'b1;
      end else if (~&stat_empty) stat_empty <= stat_empty + 1'b1;
    end
`endif
endmodule
